// File: rtl/numbotron_pkg.sv
// Shared constants and types for the numbotron counter register file and its thread.
package numbotron_pkg;

  localparam int NREGS = 8;
  localparam int REG_W = 8;
  localparam int SEL_W = 3;

  typedef logic [NREGS-1:0] reg_mask_t;
  typedef logic [REG_W-1:0] reg_val_t;

  localparam reg_val_t REG_MAX = '1;

endpackage

// File: rtl/numbotron_counter.sv
// One saturating up/down counter of the register file.
// Priority is clr > load > step, and the counter holds at zero and at all-ones.
module numbotron_counter
  import numbotron_pkg::*;
(
  input  logic     clk,
  input  logic     rstb,
  input  logic     inc,
  input  logic     dec,
  input  logic     step,
  input  logic     load,
  input  logic     clr,
  input  reg_val_t load_val,
  output reg_val_t value,
  output logic     is_zero,
  output logic     sat_hit
);

  reg_val_t value_q;
  reg_val_t value_d;
  logic     inc_only;
  logic     dec_only;

  always_comb begin
    inc_only = step & inc & ~dec;
    dec_only = step & dec & ~inc;
    // An increment only counts as attempted when clr and load have not pre-empted it.
    sat_hit  = inc_only & ~clr & ~load & (value_q == REG_MAX);
    value_d  = value_q;
    if (clr) begin
      value_d = '0;
    end else if (load) begin
      value_d = load_val;
    end else if (inc_only && (value_q != REG_MAX)) begin
      value_d = value_q + reg_val_t'(1);
    end else if (dec_only && (value_q != '0)) begin
      value_d = value_q - reg_val_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign is_zero = (value_q == '0);

endmodule

// File: rtl/numbotron_regfile.sv
// Counter register file feeding zero flags back to the numbotron thread, with edit load and readout.
// Define NUMBOTRON_OVF_EN to build the sticky per-register overflow flags; otherwise ovf is 0.
module numbotron_regfile
  import numbotron_pkg::*;
(
  input  logic             clk,
  input  logic             rstb,
  input  logic             running,
  input  logic             dostep,
  input  reg_mask_t        inc_regs,
  input  reg_mask_t        dec_regs,
  input  logic             load_en,
  input  logic [SEL_W-1:0] load_sel,
  input  reg_val_t         load_val,
  input  logic             clr_all,
  input  logic [SEL_W-1:0] rd_sel,
  output reg_val_t         rd_data,
  output reg_mask_t        zero_flags,
  output reg_mask_t        ovf
);

  logic      edit_clr;
  logic      edit_load;
  reg_mask_t load_dec;
  reg_mask_t sat_hit;
  reg_val_t  value [NREGS];
  reg_val_t  rd_data_q;
  reg_val_t  rd_data_d;

  // Edit strobes only act while the thread is stopped; an out-of-range select decodes to nothing.
  always_comb begin
    edit_clr  = ~running & clr_all;
    edit_load = ~running & load_en & ~clr_all;
    load_dec  = '0;
    for (int i = 0; i < NREGS; i++) begin
      load_dec[i] = edit_load & (load_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cnt
    numbotron_counter u_cnt (
      .clk      (clk),
      .rstb     (rstb),
      .inc      (inc_regs[g]),
      .dec      (dec_regs[g]),
      .step     (dostep),
      .load     (load_dec[g]),
      .clr      (edit_clr),
      .load_val (load_val),
      .value    (value[g]),
      .is_zero  (zero_flags[g]),
      .sat_hit  (sat_hit[g])
    );
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d = value[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

`ifdef NUMBOTRON_OVF_EN
  reg_mask_t ovf_q;
  reg_mask_t ovf_d;

  always_comb begin
    ovf_d = edit_clr ? '0 : (ovf_q | sat_hit);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_sat_hit;
  assign unused_sat_hit = ^sat_hit;
  assign ovf            = '0;
`endif

endmodule

// File: tb/tb_numbotron_regfile.sv
// Self-checking bench for numbotron_regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model of the counters.
module tb_numbotron_regfile;
  import numbotron_pkg::*;

`ifdef NUMBOTRON_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstb;
  logic             running;
  logic             dostep;
  reg_mask_t        inc_regs;
  reg_mask_t        dec_regs;
  logic             load_en;
  logic [SEL_W-1:0] load_sel;
  reg_val_t         load_val;
  logic             clr_all;
  logic [SEL_W-1:0] rd_sel;
  reg_val_t         rd_data;
  reg_mask_t        zero_flags;
  reg_mask_t        ovf;

  int        checkCount = 0;
  int        errorCount = 0;
  int        refCnt [NREGS];
  reg_mask_t refOvf;
  reg_val_t  refRd;

  always #5 clk = ~clk;

  numbotron_regfile dut (
    .clk        (clk),
    .rstb       (rstb),
    .running    (running),
    .dostep     (dostep),
    .inc_regs   (inc_regs),
    .dec_regs   (dec_regs),
    .load_en    (load_en),
    .load_sel   (load_sel),
    .load_val   (load_val),
    .clr_all    (clr_all),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .zero_flags (zero_flags),
    .ovf        (ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic reg_mask_t refZero();
    reg_mask_t z;
    for (int i = 0; i < NREGS; i++) z[i] = (refCnt[i] == 0);
    return z;
  endfunction

  // Clocks one edge with the currently driven inputs and advances the model by the same rules.
  task automatic applyStimulus();
    @(posedge clk);
    refRd = (int'(rd_sel) < NREGS) ? reg_val_t'(refCnt[rd_sel]) : '0;
    if (!rstb) begin
      for (int i = 0; i < NREGS; i++) refCnt[i] = 0;
      refOvf = '0;
      refRd  = '0;
    end else if (!running && clr_all) begin
      for (int i = 0; i < NREGS; i++) refCnt[i] = 0;
      refOvf = '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (!running && load_en && int'(load_sel) == i) begin
          refCnt[i] = int'(load_val);
        end else if (dostep && inc_regs[i] && !dec_regs[i]) begin
          if (refCnt[i] == 255) refOvf[i] = refOvf[i] | OVF_EN;
          else refCnt[i] = refCnt[i] + 1;
        end else if (dostep && dec_regs[i] && !inc_regs[i]) begin
          if (refCnt[i] > 0) refCnt[i] = refCnt[i] - 1;
        end
      end
    end
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".zero"}, 32'(zero_flags), 32'(refZero()));
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(refOvf));
    checkOutput({tag, ".rd"}, 32'(rd_data), 32'(refRd));
  endtask

  task automatic idle();
    dostep   = 1'b0;
    inc_regs = '0;
    dec_regs = '0;
    load_en  = 1'b0;
    clr_all  = 1'b0;
  endtask

  task automatic readReg(input int idx, input int expected);
    idle();
    rd_sel = SEL_W'(idx);
    applyStimulus();
    checkOutput($sformatf("rd%0d", idx), 32'(rd_data), 32'(expected));
    checkModel($sformatf("rdm%0d", idx));
  endtask

  task automatic loadReg(input int idx, input int val);
    idle();
    running  = 1'b0;
    load_en  = 1'b1;
    load_sel = SEL_W'(idx);
    load_val = reg_val_t'(val);
    applyStimulus();
    idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NREGS; i++) refCnt[i] = 0;
    refOvf   = '0;
    refRd    = '0;
    rstb     = 1'b0;
    running  = 1'b0;
    load_sel = '0;
    load_val = '0;
    rd_sel   = '0;
    idle();

    // Reset held for two clocks
    applyStimulus();
    applyStimulus();
    checkOutput("rst.zero", 32'(zero_flags), 32'hFF);
    checkOutput("rst.ovf", 32'(ovf), 32'h0);
    checkOutput("rst.rd", 32'(rd_data), 32'h0);
    rstb = 1'b1;

    // Load then step: reg1 counts down from 5, reg2 counts up from 0
    loadReg(1, 5);
    running  = 1'b1;
    dostep   = 1'b1;
    dec_regs = 8'h02;
    inc_regs = 8'h04;
    repeat (5) begin
      applyStimulus();
      checkModel("step");
    end
    checkOutput("step.z1", 32'(zero_flags[1]), 32'h1);
    checkOutput("step.z2", 32'(zero_flags[2]), 32'h0);
    readReg(1, 0);
    readReg(2, 5);

    // Decrement at zero holds
    dostep   = 1'b1;
    dec_regs = 8'h01;
    repeat (3) applyStimulus();
    checkOutput("dec0.z0", 32'(zero_flags[0]), 32'h1);
    readReg(0, 0);

    // Saturation at all-ones
    loadReg(3, 255);
    running  = 1'b1;
    dostep   = 1'b1;
    inc_regs = 8'h08;
    applyStimulus();
    checkOutput("sat.ovf3", 32'(ovf[3]), 32'(OVF_EN));
    readReg(3, 255);

    // Simultaneous inc and dec cancel
    loadReg(4, 7);
    running  = 1'b1;
    dostep   = 1'b1;
    inc_regs = 8'h10;
    dec_regs = 8'h10;
    applyStimulus();
    readReg(4, 7);

    // Load and step on different registers in the same cycle
    running  = 1'b0;
    load_en  = 1'b1;
    load_sel = 3'd5;
    load_val = 8'h33;
    dostep   = 1'b1;
    inc_regs = 8'h40;
    applyStimulus();
    readReg(5, 8'h33);
    readReg(6, 1);

    // Load ignored while running
    running  = 1'b1;
    load_en  = 1'b1;
    load_sel = 3'd5;
    load_val = 8'h99;
    applyStimulus();
    readReg(5, 8'h33);

    // clr_all in edit mode clears everything
    running = 1'b0;
    clr_all = 1'b1;
    applyStimulus();
    checkOutput("clr.zero", 32'(zero_flags), 32'hFF);
    checkOutput("clr.ovf", 32'(ovf), 32'h0);

    // Reset mid-step wins
    idle();
    running  = 1'b1;
    dostep   = 1'b1;
    inc_regs = 8'hFF;
    applyStimulus();
    rstb = 1'b0;
    applyStimulus();
    checkOutput("rststep.zero", 32'(zero_flags), 32'hFF);
    rstb = 1'b1;
    readReg(2, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rstb     = ($urandom_range(0, 49) != 0);
      running  = 1'($urandom_range(0, 1));
      dostep   = ($urandom_range(0, 3) != 0);
      inc_regs = reg_mask_t'($urandom);
      dec_regs = reg_mask_t'($urandom);
      load_en  = ($urandom_range(0, 2) == 0);
      load_sel = SEL_W'($urandom);
      case ($urandom_range(0, 3))
        0:       load_val = 8'hFF;
        1:       load_val = 8'hFE;
        2:       load_val = 8'h01;
        default: load_val = reg_val_t'($urandom);
      endcase
      clr_all  = ($urandom_range(0, 19) == 0);
      rd_sel   = SEL_W'($urandom);
      applyStimulus();
      checkModel("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
